// File: rtl/wbu_codeword_serializer.sv
// Pops 36-bit codewords from a first-word-fall-through FIFO and streams them MSB-first
// as 6-bit symbols; a prefix length code selects 1, 2, 3 or 6 symbols per word.
module wbu_codeword_serializer #(
    parameter int unsigned BW   = 36,
    parameter int unsigned SYMW = 6
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_fifo_empty_n,
    input  logic [BW-1:0]   i_fifo_data,
    output logic            o_fifo_rd,
    output logic            o_stb,
    output logic [SYMW-1:0] o_sym,
    input  logic            i_busy,
    output logic            o_active
);

    typedef enum logic {IDLE, SEND} state_t;

    state_t        state;
    logic [BW-1:0] sreg;
    logic [2:0]    count;

    // Symbols to emit, decoded from the three leading bits of the word.
    function automatic logic [2:0] word_len(input logic [BW-1:0] w);
        if (w[BW-1])      return 3'd6;
        else if (w[BW-2]) return 3'd3;
        else if (w[BW-3]) return 3'd2;
        else              return 3'd1;
    endfunction

    assign o_stb    = (state == SEND);
    assign o_active = o_stb;
    assign o_sym    = sreg[BW-1 -: SYMW];

    // Pop when idle, or when the last symbol of the current word is accepted.
    assign o_fifo_rd = !i_reset && i_fifo_empty_n
                       && (!o_stb || (!i_busy && count == 3'd1));

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state <= IDLE;
            sreg  <= '0;
            count <= '0;
        end else if (o_fifo_rd) begin
            state <= SEND;
            sreg  <= i_fifo_data;
            count <= word_len(i_fifo_data);
        end else if (state == SEND && !i_busy) begin
            if (count == 3'd1) begin
                state <= IDLE;
                count <= '0;
            end else begin
                sreg  <= sreg << SYMW;
                count <= count - 3'd1;
            end
        end
    end

endmodule
